engine_stride_index_multilane: RTL and testbench
================================================

Name: engine_stride_index_multilane

Overview:
- Parametrised successor to the single-stream stride index generator.
- Produces an index sequence from index_start toward index_end in steps of stride, in increment or decrement mode.
- Deals chunks of `granularity` consecutive indices round-robin across NUM_LANES independent valid/ready output lanes.
- Sits between the CU configuration path and the per-lane read/write engines. Adds pause/resume, overflow-safe termination, a config error flag and an issued-index counter.

Parameters:
- NUM_LANES, 4, number of output lanes (1..16).
- ADDR_W, M_AXI_MEMORY_ADDR_WIDTH, width of index and counter.
- COUNT_W, 32, width of issued_count_out.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- config_in  in  $bits(StrideIndexConfiguration)  valid + param + meta.
- config_ready_out  out  1  high only in IDLE.
- pause_in  in  1  level; stops new issues while high.
- lane_out_valid  out  NUM_LANES  per-lane index valid.
- lane_out_index  out  NUM_LANES*ADDR_W  per-lane index; lane l occupies bits [l*ADDR_W +: ADDR_W].
- lane_out_meta  out  NUM_LANES*$bits(MemoryPacketMeta)  latched config meta, replicated per lane.
- lane_in_ready  in  NUM_LANES  per-lane consumer ready.
- done_out  out  1  all indices issued and all lanes drained.
- error_out  out  1  invalid mode config.
- issued_count_out  out  COUNT_W  indices issued since last config.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Port names are ap_clk and ap_rst_n.
- Reset values: all lane_out_valid=0, indices=0, meta=0, done_out=0, error_out=0, issued_count_out=0, config_ready_out=0. The FSM is in RESET and moves to IDLE on the first clock after release.
- Reset mid-operation: immediately clears all state and outputs. No partial output survives.
- FSM states: RESET, IDLE, SETUP, START, BUSY, PAUSE, DONE.
- IDLE:
  - config_ready_out=1.
  - config_in.valid latches param and meta, clears issued_count_out, done_out and error_out, then goes to SETUP.
- SETUP (1 cycle):
  - Granularity of 0 is normalised to 1.
  - increment==decrement (both 0 or both 1) sets error_out=1, goes to DONE, issues nothing.
  - Otherwise cur_idx=index_start, lane_ptr=0, chunk_cnt=0, go to START.
- START (1 cycle): empty-range check.
  - Increment mode: the range is empty when start>=end; go to DONE.
  - Decrement mode: the range is empty when start<=end; go to DONE.
  - Otherwise go to BUSY.
- BUSY issue condition: the lane at lane_ptr has a free slot, i.e. valid==0, or valid==1 && ready==1 this cycle.
- BUSY issue action, on the same edge:
  - Load cur_idx into that lane and set valid.
  - Increment issued_count_out.
  - Advance cur_idx by ±stride.
  - chunk_cnt++. When chunk_cnt reaches granularity-1, reset it and advance lane_ptr, wrapping NUM_LANES-1 to 0.
- Strict order: a lane that is not ready stalls the whole generator. Lanes are never skipped.
- Lane slots:
  - A valid lane holds index and meta stable until its ready is seen.
  - A valid slot whose ready is seen, and which is not reloaded, clears valid.
  - Other lanes drain independently.
- Termination: stop issuing once the next index would be >=end (increment) or <=end (decrement), and go to DONE.
- Overflow/underflow: computed at ADDR_W+1 bits. Carry or borrow out is treated as end reached, so there is no wrap-around.
- Pause:
  - pause_in=1 in BUSY moves to PAUSE on the next edge; any issue qualifying on the same edge still happens.
  - PAUSE: no issues; lanes still drain. pause_in=0 returns to BUSY.
  - pause_in is ignored in all other states.
- DONE:
  - done_out=1 once all lane_out_valid are 0, and is held.
  - A new config_in.valid is not accepted until the next cycle's transition DONE→IDLE, which occurs once lanes are drained.
  - done_out and error_out clear on the next config acceptance.
- Latency and throughput: the first lane_out_valid rises 3 edges after the config handshake edge. Sustained rate is 1 index per cycle.
- Stride of 0 with a non-empty range: treated as a stride of 1.

Decomposition:
- PKG_ENGINE additions:
  - engine_stride_index_multilane_state enum.
  - StrideIndexMultiLaneConfiguration, reusing StrideIndexConfigurationParameters plus MemoryPacketMeta.
  - Constant STRIDE_INDEX_MAX_LANES=16.
- Sub-module: engine_stride_index_lane_slot, a one-entry valid/ready register with load, index and meta. It is instantiated NUM_LANES times in a generate loop.

Test Plan:
- Chunked increment: NUM_LANES=4, start=0, end=16, stride=1, gran=2, increment, all ready.
  - Lane0 gets 0,1,8,9; lane1 2,3,10,11; lane2 4,5,12,13; lane3 6,7,14,15.
  - issued_count_out=16, done_out=1, first valid 3 edges after handshake.
- Decrement: start=20, end=10, stride=3, gran=1 → lanes 0..3 get 20,17,14,11, then done_out=1. Count=4.
- Backpressure: run the chunked-increment case with lane1 ready=0 for 5 cycles after its first valid.
  - Generator stalls at lane_ptr=1 and lane1 holds index 2 stable.
  - No index reaches lane2 until release; the final sequence is unchanged.
- Pause: pause_in pulsed high for 4 cycles after 5 issues → no issues during pause, resumes at index 5, total=16, no gaps or duplicates.
- Overflow: ADDR_W=8, start=250, end=255, stride=4 → emits 250 and 254 only, done_out=1, no wrap to 2.
- Error and reset:
  - increment=decrement=1 → error_out=1, done_out=1, count=0.
  - Separately, ap_rst_n low mid-BUSY → all valids 0 asynchronously, FSM reaches IDLE after release, and a fresh config runs correctly.

Source files
------------

// File: rtl/engine_stride_index_multilane_pkg.sv
// engine_stride_index_multilane_pkg: types and constants for the multilane stride index engine
package engine_stride_index_multilane_pkg;
  localparam int M_AXI_MEMORY_ADDR_WIDTH = 32;
  localparam int STRIDE_INDEX_MAX_LANES  = 16;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] kind;
  } MemoryPacketMeta;

  typedef struct packed {
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_start;
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] index_end;
    logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] stride;
    logic [15:0]                        granularity;
    logic                               increment;
    logic                               decrement;
  } StrideIndexConfigurationParameters;

  typedef struct packed {
    StrideIndexConfigurationParameters param;
    MemoryPacketMeta                   meta;
  } StrideIndexMultiLaneConfiguration;

  typedef struct packed {
    logic                              valid;
    StrideIndexConfigurationParameters param;
    MemoryPacketMeta                   meta;
  } StrideIndexConfiguration;

  typedef enum logic [2:0] {
    STRIDE_RESET,
    STRIDE_IDLE,
    STRIDE_SETUP,
    STRIDE_START,
    STRIDE_BUSY,
    STRIDE_PAUSE,
    STRIDE_DONE
  } engine_stride_index_multilane_state;
endpackage

// File: rtl/engine_stride_index_lane_slot.sv
// engine_stride_index_lane_slot: one-entry valid/ready holding register for a single output lane
module engine_stride_index_lane_slot
  import engine_stride_index_multilane_pkg::*;
#(
  parameter int ADDR_W = M_AXI_MEMORY_ADDR_WIDTH
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] index,
  input  MemoryPacketMeta   meta,
  input  logic              ready,
  output logic              valid,
  output logic [ADDR_W-1:0] index_q,
  output MemoryPacketMeta   meta_q
);
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid   <= 1'b0;
      index_q <= '0;
      meta_q  <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      index_q <= index;
      meta_q  <= meta;
    end else if (ready) begin
      valid   <= 1'b0;
    end
  end
endmodule

// File: rtl/engine_stride_index_multilane.sv
// engine_stride_index_multilane: stride index generator dealing chunks of indices
// round-robin across NUM_LANES valid/ready lanes, with pause and carry-safe termination
module engine_stride_index_multilane
  import engine_stride_index_multilane_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int ADDR_W    = M_AXI_MEMORY_ADDR_WIDTH,
  parameter int COUNT_W   = 32
) (
  input  logic                                      ap_clk,
  input  logic                                      ap_rst_n,
  input  StrideIndexConfiguration                   config_in,
  output logic                                      config_ready_out,
  input  logic                                      pause_in,
  output logic [NUM_LANES-1:0]                      lane_out_valid,
  output logic [NUM_LANES*ADDR_W-1:0]               lane_out_index,
  output logic [NUM_LANES*$bits(MemoryPacketMeta)-1:0] lane_out_meta,
  input  logic [NUM_LANES-1:0]                      lane_in_ready,
  output logic                                      done_out,
  output logic                                      error_out,
  output logic [COUNT_W-1:0]                        issued_count_out
);
  localparam int PW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int MW = $bits(MemoryPacketMeta);
  localparam logic [2:0] S_RESET = STRIDE_RESET;
  localparam logic [2:0] S_IDLE  = STRIDE_IDLE;
  localparam logic [2:0] S_SETUP = STRIDE_SETUP;
  localparam logic [2:0] S_START = STRIDE_START;
  localparam logic [2:0] S_BUSY  = STRIDE_BUSY;
  localparam logic [2:0] S_PAUSE = STRIDE_PAUSE;
  localparam logic [2:0] S_DONE  = STRIDE_DONE;

  logic [2:0]                       state;
  StrideIndexMultiLaneConfiguration cfg;
  logic [ADDR_W-1:0]                cur_idx, idx_end, stride;
  logic [15:0]                      gran, chunk_cnt;
  logic [PW-1:0]                    lane_ptr;
  logic [NUM_LANES-1:0]             lane_free, load;
  logic [ADDR_W:0]                  nxt;
  logic                             inc, issue, end_hit;

  assign inc              = cfg.param.increment;
  assign config_ready_out = state == S_IDLE;
  assign lane_free        = ~lane_out_valid | lane_in_ready;
  assign issue            = state == S_BUSY && lane_free[lane_ptr];
  assign load             = NUM_LANES'(issue) << lane_ptr;
  // The extra top bit of nxt catches carry/borrow so the sequence never wraps
  assign nxt     = inc ? {1'b0, cur_idx} + {1'b0, stride} : {1'b0, cur_idx} - {1'b0, stride};
  assign end_hit = nxt[ADDR_W] || (inc ? nxt[ADDR_W-1:0] >= idx_end : nxt[ADDR_W-1:0] <= idx_end);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state            <= S_RESET;
      cfg              <= '0;
      cur_idx          <= '0;
      idx_end          <= '0;
      stride           <= '0;
      gran             <= '0;
      chunk_cnt        <= '0;
      lane_ptr         <= '0;
      done_out         <= 1'b0;
      error_out        <= 1'b0;
      issued_count_out <= '0;
    end else begin
      case (state)
        S_RESET: state <= S_IDLE;
        S_IDLE: if (config_in.valid) begin
          cfg              <= {config_in.param, config_in.meta};
          issued_count_out <= '0;
          done_out         <= 1'b0;
          error_out        <= 1'b0;
          state            <= S_SETUP;
        end
        S_SETUP: begin
          gran      <= cfg.param.granularity == '0 ? 16'd1 : cfg.param.granularity;
          stride    <= ADDR_W'(cfg.param.stride) == '0 ? ADDR_W'(1) : ADDR_W'(cfg.param.stride);
          cur_idx   <= ADDR_W'(cfg.param.index_start);
          idx_end   <= ADDR_W'(cfg.param.index_end);
          lane_ptr  <= '0;
          chunk_cnt <= '0;
          error_out <= cfg.param.increment == cfg.param.decrement;
          state     <= cfg.param.increment == cfg.param.decrement ? S_DONE : S_START;
        end
        S_START: state <= (inc ? cur_idx >= idx_end : cur_idx <= idx_end) ? S_DONE : S_BUSY;
        S_BUSY, S_PAUSE: begin
          if (issue) begin
            issued_count_out <= issued_count_out + COUNT_W'(1);
            cur_idx          <= nxt[ADDR_W-1:0];
            chunk_cnt        <= chunk_cnt == gran - 16'd1 ? 16'd0 : chunk_cnt + 16'd1;
            if (chunk_cnt == gran - 16'd1)
              lane_ptr <= lane_ptr == PW'(NUM_LANES - 1) ? '0 : lane_ptr + PW'(1);
          end
          state <= issue && end_hit             ? S_DONE  :
                   state == S_BUSY && pause_in  ? S_PAUSE :
                   state == S_PAUSE && !pause_in ? S_BUSY : state;
        end
        S_DONE: if (~|lane_out_valid) begin
          done_out <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    engine_stride_index_lane_slot #(.ADDR_W(ADDR_W)) u_slot (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .load     (load[l]),
      .index    (cur_idx),
      .meta     (cfg.meta),
      .ready    (lane_in_ready[l]),
      .valid    (lane_out_valid[l]),
      .index_q  (lane_out_index[l*ADDR_W +: ADDR_W]),
      .meta_q   (lane_out_meta[l*MW +: MW])
    );
  end
endmodule

// File: tb/tb_engine_stride_index_multilane.sv
// tb_engine_stride_index_multilane: scoreboard bench, directed stimulus with per-lane expected queues
module tb_engine_stride_index_multilane;
  import engine_stride_index_multilane_pkg::*;
  localparam int NL = 4;
  localparam int AW = 8;
  localparam int CW = 32;
  localparam int MW = $bits(MemoryPacketMeta);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    pause = 1'b0;
  logic                    cfg_ready, done, error;
  StrideIndexConfiguration cfg_in = '0;
  logic [NL-1:0]           valid;
  logic [NL-1:0]           ready = '1;
  logic [NL*AW-1:0]        index;
  logic [NL*MW-1:0]        meta;
  logic [CW-1:0]           count;
  logic [23:0]             exp_q[NL][$];
  logic [23:0]             e;
  logic [15:0]             cur_meta = '0;
  int                      checks = 0;
  int                      failures = 0;
  int                      n;

  always #5 clk = ~clk;

  engine_stride_index_multilane #(.NUM_LANES(NL), .ADDR_W(AW), .COUNT_W(CW)) dut (
    .ap_clk           (clk),
    .ap_rst_n         (rst_n),
    .config_in        (cfg_in),
    .config_ready_out (cfg_ready),
    .pause_in         (pause),
    .lane_out_valid   (valid),
    .lane_out_index   (index),
    .lane_out_meta    (meta),
    .lane_in_ready    (ready),
    .done_out         (done),
    .error_out        (error),
    .issued_count_out (count)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push(int l, int v);
    exp_q[l].push_back({cur_meta, 8'(v)});
  endtask

  task automatic push_chunked();
    push(0, 0); push(0, 1); push(0, 8);  push(0, 9);
    push(1, 2); push(1, 3); push(1, 10); push(1, 11);
    push(2, 4); push(2, 5); push(2, 12); push(2, 13);
    push(3, 6); push(3, 7); push(3, 14); push(3, 15);
  endtask

  // Transfer happens on the next rising edge when valid && ready at the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < NL; l++) begin
        if (valid[l] && ready[l]) begin
          if (exp_q[l].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL lane%0d_unexpected actual=%0d required=none", l, index[l*AW +: AW]);
          end else begin
            e = exp_q[l].pop_front();
            check($sformatf("lane%0d_index", l), 64'(index[l*AW +: AW]), 64'(e[7:0]));
            check($sformatf("lane%0d_meta", l), 64'(meta[l*MW +: MW]), 64'(e[23:8]));
          end
        end
      end
    end
  end

  task automatic start_cfg(int s, int en, int st, int g, bit inc, bit dec);
    int k = 0;
    while (!cfg_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("cfg_ready", 64'(cfg_ready), 64'd1);
    cfg_in                   = '0;
    cfg_in.valid             = 1'b1;
    cfg_in.param.index_start = 32'(s);
    cfg_in.param.index_end   = 32'(en);
    cfg_in.param.stride      = 32'(st);
    cfg_in.param.granularity = 16'(g);
    cfg_in.param.increment   = inc;
    cfg_in.param.decrement   = dec;
    cfg_in.meta              = cur_meta;
    @(posedge clk); #1;
    cfg_in.valid = 1'b0;
  endtask

  task automatic wait_done(string tag, int exp_count, bit exp_err);
    int k = 0;
    int left = 0;
    while (!done && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_count"}, 64'(count), 64'(exp_count));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    for (int l = 0; l < NL; l++) left += exp_q[l].size();
    check({tag, "_leftover"}, 64'(left), 64'd0);
  endtask

  initial begin
    #12;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_index", 64'(index), 64'd0);
    check("rst_meta", 64'(meta), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // chunked increment with first-valid latency
    cur_meta = 16'hA53C;
    push_chunked();
    start_cfg(0, 16, 1, 2, 1'b1, 1'b0);
    n = 0;
    while (valid == '0 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("first_valid_latency", 64'(n), 64'd3);
    wait_done("chunked", 16, 1'b0);

    // decrement, one index per lane
    cur_meta = 16'h1234;
    push(0, 20); push(1, 17); push(2, 14); push(3, 11);
    start_cfg(20, 10, 3, 1, 1'b0, 1'b1);
    wait_done("decrement", 4, 1'b0);

    // lane1 backpressure stalls the whole generator
    cur_meta = 16'h00B1;
    push_chunked();
    start_cfg(0, 16, 1, 2, 1'b1, 1'b0);
    n = 0;
    while (!valid[1] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ready[1] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(valid[1]), 64'd1);
      check("bp_hold_index", 64'(index[AW +: AW]), 64'd2);
      check("bp_lane2_idle", 64'(valid[2]), 64'd0);
    end
    ready[1] = 1'b1;
    wait_done("backpressure", 16, 1'b0);

    // pause after the fifth issue
    cur_meta = 16'h0C0D;
    push_chunked();
    start_cfg(0, 16, 1, 2, 1'b1, 1'b0);
    n = 0;
    while (count != 4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    pause = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("pause_count", 64'(count), 64'd5);
    end
    pause = 1'b0;
    @(posedge clk); #1;
    check("pause_resume_edge", 64'(count), 64'd5);
    wait_done("pause", 16, 1'b0);

    // carry out of the 8-bit index ends the run instead of wrapping to 2
    cur_meta = 16'hFFEE;
    push(0, 250); push(1, 254);
    start_cfg(250, 255, 4, 1, 1'b1, 1'b0);
    wait_done("overflow", 2, 1'b0);

    // increment and decrement both set
    start_cfg(0, 16, 1, 1, 1'b1, 1'b1);
    wait_done("bad_mode", 0, 1'b1);

    // reset in the middle of a run, then a fresh run
    cur_meta = 16'h7777;
    push_chunked();
    start_cfg(0, 16, 1, 2, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_cfg_ready", 64'(cfg_ready), 64'd0);
    for (int l = 0; l < NL; l++) exp_q[l].delete();
    @(negedge clk);
    rst_n = 1'b1;
    cur_meta = 16'h4321;
    push(0, 20); push(1, 17); push(2, 14); push(3, 11);
    start_cfg(20, 10, 3, 1, 1'b0, 1'b1);
    wait_done("after_reset", 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
